// File: rtl/iob_fp_unpack_if.sv
// Handshake and result bundle for the FP operand unpacker.
// The slave side is the unpacker; the master side drives operands and consumes results.
interface iob_fp_unpack_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned EXP_W  = 8
);
    localparam int unsigned MAN_W = DATA_W - EXP_W;

    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_i;
    logic              valid_o;
    logic              ready_i;
    logic              sign_o;
    logic [EXP_W+1:0]  exp_o;
    logic [MAN_W-1:0]  man_o;
    logic              nan_o;
    logic              infinite_o;
    logic              zero_o;
    logic              sub_normal_o;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, sign_o, exp_o, man_o,
               nan_o, infinite_o, zero_o, sub_normal_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, sign_o, exp_o, man_o,
               nan_o, infinite_o, zero_o, sub_normal_o
    );
endinterface

// File: rtl/iob_fp_unpack.sv
// Two-stage IEEE-754 operand unpacker: classify + leading-zero count, then
// unbias exponent and renormalise subnormals so every finite non-zero has man_o MSB set.
module iob_fp_unpack #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned EXP_W  = 8
) (
    input  logic          clk_i,
    input  logic          arst_n_i,
    iob_fp_unpack_if.slave io
);
    localparam int unsigned MAN_W = DATA_W - EXP_W;
    localparam int unsigned FRAC_W = MAN_W - 1;
    localparam int unsigned BIAS  = 2 ** (EXP_W - 1) - 1;
    localparam int unsigned LZ_W  = $clog2(FRAC_W);
    localparam int unsigned EO_W  = EXP_W + 2;
    localparam logic [EO_W-1:0] BiasX    = BIAS[EO_W-1:0];
    localparam logic [EO_W-1:0] SpecialX = BiasX + 1'b1;

    logic en1, en2;

    // Stage-1 registers
    logic              v1_q;
    logic              sign1_q;
    logic [EXP_W-1:0]  expf_q;
    logic [FRAC_W-1:0] frac_q;
    logic              nan1_q, inf1_q, zero1_q, sub1_q;
    logic [LZ_W-1:0]   lz_q;

    // Stage-2 registers (drive the outputs directly)
    logic              v2_q;
    logic              sign2_q;
    logic [EO_W-1:0]   exp2_q;
    logic [MAN_W-1:0]  man2_q;
    logic              nan2_q, inf2_q, zero2_q, sub2_q;

    logic [EXP_W-1:0]  exp_in;
    logic [FRAC_W-1:0] frac_in;
    logic              exp_ones, exp_zero, frac_zero;
    logic [LZ_W-1:0]   lz_d;
    logic [EO_W-1:0]   exp2_d;
    logic [MAN_W-1:0]  man2_d;

    assign en2 = ~v2_q | io.ready_i;
    assign en1 = ~v1_q | en2;

    assign exp_in    = io.data_i[DATA_W-2 -: EXP_W];
    assign frac_in   = io.data_i[FRAC_W-1:0];
    assign exp_ones  = &exp_in;
    assign exp_zero  = ~|exp_in;
    assign frac_zero = ~|frac_in;

    // Scan LSB->MSB so the highest set bit wins.
    always_comb begin
        lz_d = '0;
        for (int unsigned i = 0; i < FRAC_W; i++) begin
            if (frac_in[i]) lz_d = LZ_W'(FRAC_W - 1 - i);
        end
    end

    always_comb begin
        exp2_d = '0;
        man2_d = '0;
        if (nan1_q || inf1_q) begin
            exp2_d = SpecialX;
            man2_d = {1'b0, frac_q};
        end else if (zero1_q) begin
            exp2_d = '0;
            man2_d = '0;
        end else if (sub1_q) begin
            exp2_d = '0 - BiasX - {{(EO_W - LZ_W){1'b0}}, lz_q};
            man2_d = {frac_q, 1'b0} << lz_q;
        end else begin
            exp2_d = {2'b00, expf_q} - BiasX;
            man2_d = {1'b1, frac_q};
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            expf_q  <= '0;
            frac_q  <= '0;
            nan1_q  <= 1'b0;
            inf1_q  <= 1'b0;
            zero1_q <= 1'b0;
            sub1_q  <= 1'b0;
            lz_q    <= '0;
        end else if (en1) begin
            v1_q    <= io.valid_i;
            sign1_q <= io.data_i[DATA_W-1];
            expf_q  <= exp_in;
            frac_q  <= frac_in;
            nan1_q  <= exp_ones & ~frac_zero;
            inf1_q  <= exp_ones & frac_zero;
            zero1_q <= exp_zero & frac_zero;
            sub1_q  <= exp_zero & ~frac_zero;
            lz_q    <= lz_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            exp2_q  <= '0;
            man2_q  <= '0;
            nan2_q  <= 1'b0;
            inf2_q  <= 1'b0;
            zero2_q <= 1'b0;
            sub2_q  <= 1'b0;
        end else if (en2) begin
            v2_q    <= v1_q;
            sign2_q <= sign1_q;
            exp2_q  <= exp2_d;
            man2_q  <= man2_d;
            nan2_q  <= nan1_q;
            inf2_q  <= inf1_q;
            zero2_q <= zero1_q;
            sub2_q  <= sub1_q;
        end
    end

    assign io.ready_o      = en1;
    assign io.valid_o      = v2_q;
    assign io.sign_o       = sign2_q;
    assign io.exp_o        = exp2_q;
    assign io.man_o        = man2_q;
    assign io.nan_o        = nan2_q;
    assign io.infinite_o   = inf2_q;
    assign io.zero_o       = zero2_q;
    assign io.sub_normal_o = sub2_q;
endmodule

// File: tb/tb_iob_fp_unpack.sv
// Scoreboard bench for iob_fp_unpack: driver pushes expected results on accept,
// a negedge monitor pops and compares on every output transfer.
module tb_iob_fp_unpack;
    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [23:0] m;
        logic        n;
        logic        i;
        logic        z;
        logic        sb;
    } res_t;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rmode = 0;
    res_t exp_q[$];

    iob_fp_unpack_if #(.DATA_W(32), .EXP_W(8)) bus ();

    iob_fp_unpack #(.DATA_W(32), .EXP_W(8)) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .io       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h need %h", name, act, req);
        end
    endtask

    function automatic res_t mk(input logic s, input logic [9:0] e, input logic [23:0] m,
                                input logic [3:0] fl);
        res_t r;
        r = '{s: s, e: e, m: m, n: fl[3], i: fl[2], z: fl[1], sb: fl[0]};
        return r;
    endfunction

    // Reference: value-level view. Subnormals are F*2^-149; normalise by doubling.
    function automatic res_t model(input logic [31:0] d);
        res_t        r;
        logic [7:0]  ef;
        logic [22:0] f;
        logic [23:0] m;
        int          e;
        ef = d[30:23];
        f  = d[22:0];
        r  = '0;
        r.s = d[31];
        if (ef == 8'hFF) begin
            r.e = 10'd128;
            r.m = {1'b0, f};
            r.n = (f != 0);
            r.i = (f == 0);
        end else if (ef == 0 && f == 0) begin
            r.z = 1'b1;
        end else if (ef == 0) begin
            m = {1'b0, f};
            e = -126;
            while (!m[23]) begin
                m = m << 1;
                e--;
            end
            r.e  = 10'(e);
            r.m  = m;
            r.sb = 1'b1;
        end else begin
            r.e = 10'(int'(ef) - 127);
            r.m = {1'b1, f};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] d;
        d = $urandom;
        case ($urandom_range(0, 5))
            0: d[30:23] = 8'h00;
            1: d[30:0]  = '0;
            2: begin
                d[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) d[22:0] = '0;
            end
            default: ;
        endcase
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        case (rmode)
            1: bus.ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
            2: bus.ready_i = ($urandom_range(0, 3) != 0);
            default: ;
        endcase
    endtask

    task automatic send(input logic [31:0] d, input res_t r);
        bit acc;
        acc = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clk);
            acc = bus.ready_o;
            if (acc) exp_q.push_back(r);
            step();
        end
        chk("accept", 64'(acc), 64'd1);
        bus.valid_i = 1'b0;
    endtask

    function automatic res_t cur_out();
        res_t r;
        r = '{s: bus.sign_o, e: bus.exp_o, m: bus.man_o, n: bus.nan_o,
              i: bus.infinite_o, z: bus.zero_o, sb: bus.sub_normal_o};
        return r;
    endfunction

    // Monitor
    initial begin
        res_t cur;
        res_t held;
        res_t want;
        bit   hold_vld;
        hold_vld = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                hold_vld = 1'b0;
            end else begin
                cur = cur_out();
                if (hold_vld) begin
                    chk("hold_valid", 64'(bus.valid_o), 64'd1);
                    chk("hold_data", 64'(cur), 64'(held));
                end
                if (bus.valid_o && bus.ready_i) begin
                    chk("out_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        want = exp_q.pop_front();
                        chk("result", 64'(cur), 64'(want));
                    end
                    hold_vld = 1'b0;
                end else if (bus.valid_o) begin
                    hold_vld = 1'b1;
                    held = cur;
                end else begin
                    hold_vld = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [31:0] d;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_ready", 64'(bus.ready_o), 64'd1);
        chk("rst_outs", 64'(cur_out()), 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        step();

        // 1.0 with latency check
        send(32'h3F800000, mk(1'b0, 10'd0, 24'h800000, 4'b0000));
        @(negedge clk);
        chk("lat_early", 64'(bus.valid_o), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(bus.valid_o), 64'd1);
        step();

        send(32'h00000001, mk(1'b0, 10'h36B, 24'h800000, 4'b0001));
        send(32'hFF800000, mk(1'b1, 10'd128, 24'h000000, 4'b0100));
        send(32'h7FC00001, mk(1'b0, 10'd128, 24'h400001, 4'b1000));
        send(32'h80000000, mk(1'b1, 10'd0, 24'h000000, 4'b0010));
        send(32'h7F7FFFFF, mk(1'b0, 10'd127, 24'hFFFFFF, 4'b0000));
        repeat (4) step();

        // Stream with ready_i pattern 1,0,0,1
        rmode = 1;
        for (int k = 0; k < 8; k++) begin
            d = rand_fp();
            send(d, model(d));
        end

        // Random traffic with random backpressure and gaps
        rmode = 2;
        for (int k = 0; k < 150; k++) begin
            d = rand_fp();
            send(d, model(d));
            if ($urandom_range(0, 3) == 0) step();
        end
        rmode = 0;
        bus.ready_i = 1'b1;
        repeat (6) step();

        // Fill, stall, reset mid-flight
        bus.ready_i = 1'b0;
        d = rand_fp();
        send(d, model(d));
        d = rand_fp();
        send(d, model(d));
        @(negedge clk);
        chk("full_stall", 64'(bus.ready_o), 64'd0);
        #1;
        arst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.valid_o), 64'd0);
        chk("mid_rst_outs", 64'(cur_out()), 64'd0);
        chk("mid_rst_ready", 64'(bus.ready_o), 64'd1);
        exp_q.delete();
        @(negedge clk);
        arst_n = 1'b1;
        bus.ready_i = 1'b1;
        step();
        send(32'h00000001, mk(1'b0, 10'h36B, 24'h800000, 4'b0001));
        @(negedge clk);
        chk("post_rst_early", 64'(bus.valid_o), 64'd0);
        @(negedge clk);
        chk("post_rst_valid", 64'(bus.valid_o), 64'd1);
        step();

        for (int n = 0; n < 50 && exp_q.size() > 0; n++) step();
        repeat (3) step();
        chk("drain", 64'(exp_q.size()), 64'd0);
        chk("idle_valid", 64'(bus.valid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
